// File: rtl/cross_clock_pkg.sv
// Shared definitions for the cross-clock enable bank.
// Contents:
//   clog2()      - ceiling log2, usable in constant expressions
//   MIN_*        - lower bounds for the synchroniser depth and filter length
//   params_ok()  - elaboration-time legality check for the bank parameters
package cross_clock_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned MIN_FILTER_LEN  = 1;

  // clog2(1) = 0, clog2(2) = 1, clog2(3) = 2, clog2(5) = 3
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  function automatic bit params_ok(input int unsigned channels,
                                   input int unsigned sync_stages,
                                   input int unsigned filter_len,
                                   input int unsigned glitch_w);
    return (channels >= 1) && (sync_stages >= MIN_SYNC_STAGES) &&
           (filter_len >= MIN_FILTER_LEN) && (glitch_w >= 1);
  endfunction

endpackage

// File: rtl/cross_clock_filter_ch.sv
// One enable channel: synchroniser chain, consecutive-sample debounce filter with
// hysteresis, and registered rise/fall pulses.
// Optional macro: CROSS_CLOCK_GLITCH_COUNT_EN adds o_glitch.
// Ports:
//   i_clk     - destination clock
//   i_rst_n   - asynchronous active-low reset
//   i_en      - asynchronous level enable
//   o_en      - filtered, synchronised level
//   o_rise    - one-cycle pulse on o_en 0->1
//   o_fall    - one-cycle pulse on o_en 1->0
//   o_glitch  - (macro only) a partially qualified transition aborted this edge
module cross_clock_filter_ch
  import cross_clock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES,
  parameter int unsigned FILTER_LEN  = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_en,
  output logic o_rise,
  output logic o_fall
`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
  ,
  output logic o_glitch
`endif
);

  localparam int unsigned      CNT_W    = clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_d;
  logic                   r_en;
  logic                   w_en_d;
  logic                   r_rise;
  logic                   w_rise_d;
  logic                   r_fall;
  logic                   w_fall_d;
  logic                   w_s;

  // Only the last flop of the chain feeds logic; the chain itself is pure flops.
  assign w_s = r_sync[SYNC_STAGES-1];

  // Any sample agreeing with the current level restarts qualification.
  always_comb begin
    w_cnt_d  = '0;
    w_en_d   = r_en;
    w_rise_d = 1'b0;
    w_fall_d = 1'b0;
    if (w_s != r_en) begin
      if (r_cnt == CNT_LAST) begin
        w_en_d   = w_s;
        w_rise_d = w_s;
        w_fall_d = ~w_s;
      end else begin
        w_cnt_d = r_cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_en   <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_en};
      r_cnt  <= w_cnt_d;
      r_en   <= w_en_d;
      r_rise <= w_rise_d;
      r_fall <= w_fall_d;
    end
  end

  assign o_en   = r_en;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
  assign o_glitch = (r_cnt != '0) && (w_s == r_en);
`endif

endmodule

// File: rtl/cross_clock_enable_bank.sv
// Multi-channel enable synchroniser: brings CHANNELS independent level enables
// from foreign clock domains into out_clk, each debounced and edge-pulsed.
// Optional macro: CROSS_CLOCK_GLITCH_COUNT_EN adds glitch_clr / glitch_cnt, a
// saturating count of aborted transitions summed across all channels.
// Ports:
//   out_clk    - destination clock (only clock)
//   rst_n      - asynchronous active-low reset
//   in_en      - asynchronous level enables, one per channel
//   out_en     - filtered, synchronised levels
//   out_rise   - one-cycle pulse per channel on out_en 0->1
//   out_fall   - one-cycle pulse per channel on out_en 1->0
//   glitch_clr - (macro only) synchronous clear of glitch_cnt, wins over increment
//   glitch_cnt - (macro only) saturating rejected-transition count
module cross_clock_enable_bank
  import cross_clock_pkg::*;
#(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILTER_LEN  = 2,
  parameter int unsigned GLITCH_W    = 8
) (
  input  logic                out_clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] in_en,
  output logic [CHANNELS-1:0] out_en,
  output logic [CHANNELS-1:0] out_rise,
  output logic [CHANNELS-1:0] out_fall
`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
  ,
  input  logic                glitch_clr,
  output logic [GLITCH_W-1:0] glitch_cnt
`endif
);

  if (!params_ok(CHANNELS, SYNC_STAGES, FILTER_LEN, GLITCH_W)) begin : g_param_err
    $error("cross_clock_enable_bank: illegal parameter combination");
  end

`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
  logic [CHANNELS-1:0] w_glitch;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    cross_clock_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
    ) u_ch (
      .i_clk    (out_clk),
      .i_rst_n  (rst_n),
      .i_en     (in_en[g]),
      .o_en     (out_en[g]),
      .o_rise   (out_rise[g]),
      .o_fall   (out_fall[g])
`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
      ,
      .o_glitch (w_glitch[g])
`endif
    );
  end

`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
  // Extra headroom so the sum can never wrap before the saturation compare.
  localparam int unsigned      SUM_W      = GLITCH_W + clog2(CHANNELS + 1);
  localparam logic [SUM_W-1:0] GLITCH_MAX = {{(SUM_W - GLITCH_W){1'b0}}, {GLITCH_W{1'b1}}};

  logic [GLITCH_W-1:0] r_glitch_cnt;
  logic [SUM_W-1:0]    w_pop;
  logic [SUM_W-1:0]    w_sum;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      w_pop = w_pop + SUM_W'(w_glitch[i]);
    end
  end

  assign w_sum = SUM_W'(r_glitch_cnt) + w_pop;

  always_ff @(posedge out_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch_cnt <= '0;
    end else if (glitch_clr) begin
      r_glitch_cnt <= '0;
    end else if (w_sum > GLITCH_MAX) begin
      r_glitch_cnt <= '1;
    end else begin
      r_glitch_cnt <= GLITCH_W'(w_sum);
    end
  end

  assign glitch_cnt = r_glitch_cnt;
`endif

endmodule

// File: tb/tb_cross_clock_enable_bank.sv
// Bench for cross_clock_enable_bank. Two instances: A uses the default
// parameters, B uses SYNC_STAGES=3, FILTER_LEN=4, GLITCH_W=2. A history-window
// model derives every output from the recorded input samples each cycle.
module tb_cross_clock_enable_bank;

  localparam int CH   = 4;
  localparam int SS_A = 2;
  localparam int FL_A = 2;
  localparam int GW_A = 8;
  localparam int SS_B = 3;
  localparam int FL_B = 4;
  localparam int GW_B = 2;
  localparam int MAXE = 4096;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic [CH-1:0] in_en      = '0;
  logic          glitch_clr = 1'b0;

  logic [CH-1:0] out_en_a, out_rise_a, out_fall_a;
  logic [CH-1:0] out_en_b, out_rise_b, out_fall_b;
`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
  logic [GW_A-1:0] glitch_cnt_a;
  logic [GW_B-1:0] glitch_cnt_b;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit t3_pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  cross_clock_enable_bank #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS_A),
    .FILTER_LEN  (FL_A),
    .GLITCH_W    (GW_A)
  ) dut_a (
    .out_clk    (clk),
    .rst_n      (rst_n),
    .in_en      (in_en),
    .out_en     (out_en_a),
    .out_rise   (out_rise_a),
    .out_fall   (out_fall_a)
`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
    ,
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt_a)
`endif
  );

  cross_clock_enable_bank #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS_B),
    .FILTER_LEN  (FL_B),
    .GLITCH_W    (GW_B)
  ) dut_b (
    .out_clk    (clk),
    .rst_n      (rst_n),
    .in_en      (in_en),
    .out_en     (out_en_b),
    .out_rise   (out_rise_b),
    .out_fall   (out_fall_b)
`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
    ,
    .glitch_clr (glitch_clr),
    .glitch_cnt (glitch_cnt_b)
`endif
  );

  // ---------------- model ----------------
  // Edge t (1-based since reset) records in_en in m_hist; the synchronised sample
  // used at edge t is the input recorded SS edges earlier. A level changes when
  // the last FL samples, all taken after the previous change, disagree with it.
  logic [CH-1:0] m_hist [2][MAXE];
  int            m_t    [2];
  int            m_last [2][CH];
  logic [CH-1:0] m_en   [2];
  logic [CH-1:0] m_rise [2];
  logic [CH-1:0] m_fall [2];
  int            m_gl   [2];

  function automatic int ss_of(input int m);
    return (m == 0) ? SS_A : SS_B;
  endfunction

  function automatic int fl_of(input int m);
    return (m == 0) ? FL_A : FL_B;
  endfunction

  function automatic int gmax_of(input int m);
    return (m == 0) ? ((1 << GW_A) - 1) : ((1 << GW_B) - 1);
  endfunction

  function automatic logic s_at(input int m, input int t, input int ch);
    int idx;
    idx = t - ss_of(m);
    if (idx < 1) return 1'b0;
    return m_hist[m][idx][ch];
  endfunction

  task automatic model_clear(input int m);
    m_t[m]    = 0;
    m_en[m]   = '0;
    m_rise[m] = '0;
    m_fall[m] = '0;
    m_gl[m]   = 0;
    for (int ch = 0; ch < CH; ch++) m_last[m][ch] = 0;
  endtask

  task automatic model_step(input int m);
    int t;
    int sum;
    bit ok;
    logic cur;
    if (m_t[m] >= MAXE - 1) begin
      $display("FAIL model_history: edge count %0d required below %0d", m_t[m], MAXE - 1);
      $fatal(1);
    end
    m_t[m] = m_t[m] + 1;
    t = m_t[m];
    m_hist[m][t] = in_en;
    m_rise[m] = '0;
    m_fall[m] = '0;
    sum = 0;
    for (int ch = 0; ch < CH; ch++) begin
      cur = m_en[m][ch];
      if (s_at(m, t, ch) == cur && (t - 1) > m_last[m][ch] && s_at(m, t - 1, ch) != cur)
        sum++;
      ok = 1'b1;
      for (int k = 0; k < fl_of(m); k++) begin
        if ((t - k) <= m_last[m][ch] || s_at(m, t - k, ch) == cur) ok = 1'b0;
      end
      if (ok) begin
        m_en[m][ch]   = ~cur;
        m_last[m][ch] = t;
        m_rise[m][ch] = ~cur;
        m_fall[m][ch] = cur;
      end
    end
    if (glitch_clr) m_gl[m] = 0;
    else if (m_gl[m] + sum > gmax_of(m)) m_gl[m] = gmax_of(m);
    else m_gl[m] = m_gl[m] + sum;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_clear(0);
      model_clear(1);
    end else begin
      model_step(0);
      model_step(1);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc out_en_a",   32'(out_en_a),   32'(m_en[0]));
    check("cyc out_rise_a", 32'(out_rise_a), 32'(m_rise[0]));
    check("cyc out_fall_a", 32'(out_fall_a), 32'(m_fall[0]));
    check("cyc out_en_b",   32'(out_en_b),   32'(m_en[1]));
    check("cyc out_rise_b", 32'(out_rise_b), 32'(m_rise[1]));
    check("cyc out_fall_b", 32'(out_fall_b), 32'(m_fall[1]));
`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
    check("cyc glitch_cnt_a", 32'(glitch_cnt_a), 32'(m_gl[0]));
    check("cyc glitch_cnt_b", 32'(glitch_cnt_b), 32'(m_gl[1]));
`endif
  end

  // Inputs change 1 time unit after a falling edge; step(k+1) after a drive
  // lands just after the k-th rising edge following it (edge 0 samples the drive).
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_en = '0;
    step(2);
  endtask

  initial begin
    step(1);
    check("reset out_en_a",   32'(out_en_a),   32'h0);
    check("reset out_rise_a", 32'(out_rise_a), 32'h0);
    check("reset out_en_b",   32'(out_en_b),   32'h0);

    // 1: single channel rise, default latency 3, B latency 6
    in_en = 4'b0001;
    rst_n = 1'b1;
    step(3);
    check("t1 e2 out_en_a", 32'(out_en_a), 32'h0);
    step(1);
    check("t1 e3 out_en_a",   32'(out_en_a),   32'h1);
    check("t1 e3 out_rise_a", 32'(out_rise_a), 32'h1);
    step(1);
    check("t1 e4 out_rise_a", 32'(out_rise_a), 32'h0);
    check("t1 e4 out_en_a",   32'(out_en_a),   32'h1);
    step(1);
    check("t1 e5 out_en_b", 32'(out_en_b), 32'h0);
    step(1);
    check("t1 e6 out_en_b",   32'(out_en_b),   32'h1);
    check("t1 e6 out_rise_b", 32'(out_rise_b), 32'h1);

    // 2: one-period pulse is rejected
    do_reset();
    rst_n = 1'b1;
    step(2);
    in_en = 4'b0010;
    step(1);
    in_en = 4'b0000;
    step(10);
    check("t2 out_en_a", 32'(out_en_a), 32'h0);
    check("t2 out_en_b", 32'(out_en_b), 32'h0);
`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
    check("t2 glitch_cnt_a", 32'(glitch_cnt_a), 32'h1);
    check("t2 glitch_cnt_b", 32'(glitch_cnt_b), 32'h1);
`endif

    // 3: hysteresis on channel 2 with FILTER_LEN=4
    do_reset();
    rst_n = 1'b1;
    step(2);
    for (int k = 0; k < 8; k++) begin
      in_en    = 4'b0000;
      in_en[2] = t3_pat[k];
      step(1);
    end
    step(2);
    check("t3 e9 out_en_b", 32'(out_en_b), 32'h0);
    step(1);
    check("t3 e10 out_en_b",   32'(out_en_b),   32'h4);
    check("t3 e10 out_rise_b", 32'(out_rise_b), 32'h4);
`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
    check("t3 glitch_cnt_b", 32'(glitch_cnt_b), 32'h1);
    check("t3 glitch_cnt_a", 32'(glitch_cnt_a), 32'h1);
`endif

    // 4: all channels together
    do_reset();
    rst_n = 1'b1;
    in_en = 4'b1111;
    step(4);
    check("t4 rise out_en_a",   32'(out_en_a),   32'hf);
    check("t4 rise out_rise_a", 32'(out_rise_a), 32'hf);
    step(10);
    in_en = 4'b0000;
    step(4);
    check("t4 fall out_fall_a", 32'(out_fall_a), 32'hf);
    check("t4 fall out_en_a",   32'(out_en_a),   32'h0);
    step(3);
    check("t4 fall out_fall_b", 32'(out_fall_b), 32'hf);

    // 5: reset mid-qualification, full latency afterwards
    do_reset();
    rst_n = 1'b1;
    in_en = 4'b0001;
    step(8);
    in_en = 4'b0011;
    step(3);
    check("t5 pre out_en_a", 32'(out_en_a), 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5 async out_en_a", 32'(out_en_a), 32'h0);
    check("t5 async out_en_b", 32'(out_en_b), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(3);
    check("t5 e2 out_en_a", 32'(out_en_a), 32'h0);
    step(1);
    check("t5 e3 out_en_a",   32'(out_en_a),   32'h3);
    check("t5 e3 out_rise_a", 32'(out_rise_a), 32'h3);

`ifdef CROSS_CLOCK_GLITCH_COUNT_EN
    // 6: saturation and clear-wins
    do_reset();
    rst_n = 1'b1;
    step(2);
    in_en = 4'b0001;
    step(1);
    in_en = 4'b0000;
    step(8);
    in_en = 4'b1111;
    step(1);
    in_en = 4'b0000;
    step(8);
    check("t6 sat glitch_cnt_a", 32'(glitch_cnt_a), 32'h5);
    check("t6 sat glitch_cnt_b", 32'(glitch_cnt_b), 32'h3);
    in_en = 4'b0001;
    step(1);
    in_en = 4'b0000;
    step(3);
    check("t6 e3 glitch_cnt_a", 32'(glitch_cnt_a), 32'h6);
    glitch_clr = 1'b1;
    step(1);
    glitch_clr = 1'b0;
    check("t6 clr glitch_cnt_b", 32'(glitch_cnt_b), 32'h0);
    check("t6 clr glitch_cnt_a", 32'(glitch_cnt_a), 32'h0);
    step(4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
